// File: rtl/mux_n_1_stream_pkg.sv
// Shared types and constants for the N:1 streaming multiplexer.
package mux_n_1_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/mux_n_1_stream_if.sv
// Channel-side and result-side stream signals of the N:1 multiplexer.
// Stall_Count_Out exists only when MUX_N_1_STREAM_STALL_COUNT_EN is defined.
interface mux_n_1_stream_if
    import mux_n_1_stream_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int DATA_WIDTH   = 8
);
    localparam int SEL_WIDTH = $clog2(NUM_CHANNELS);

    logic                               Enable_In;
    logic                               Mode_In;
    logic [SEL_WIDTH-1:0]               Select_In;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In;
    logic [NUM_CHANNELS-1:0]            Data_Valid_In;
    logic [NUM_CHANNELS-1:0]            Data_Ready_Out;
    logic [DATA_WIDTH-1:0]              MUX_Result_Data_Out;
    logic                               MUX_Result_Valid_Out;
    logic                               MUX_Result_Ready_In;
    logic [SEL_WIDTH-1:0]               Channel_Out;
    logic                               Select_Error_Out;
`ifdef MUX_N_1_STREAM_STALL_COUNT_EN
    logic [STALL_CNT_W-1:0]             Stall_Count_Out;
`endif

    modport master (
        output Enable_In, Mode_In, Select_In, Data_In, Data_Valid_In, MUX_Result_Ready_In,
        input  Data_Ready_Out, MUX_Result_Data_Out, MUX_Result_Valid_Out, Channel_Out,
               Select_Error_Out
`ifdef MUX_N_1_STREAM_STALL_COUNT_EN
        , input Stall_Count_Out
`endif
    );

    modport slave (
        input  Enable_In, Mode_In, Select_In, Data_In, Data_Valid_In, MUX_Result_Ready_In,
        output Data_Ready_Out, MUX_Result_Data_Out, MUX_Result_Valid_Out, Channel_Out,
               Select_Error_Out
`ifdef MUX_N_1_STREAM_STALL_COUNT_EN
        , output Stall_Count_Out
`endif
    );

endinterface

// File: rtl/mux_n_1_stream_arbiter.sv
// Rotating-priority arbiter: first set request at or above pointer, wrapping.
module round_robin_arbiter
    import mux_n_1_stream_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    localparam int SEL_WIDTH   = $clog2(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] request,
    input  logic [SEL_WIDTH-1:0]    pointer,
    output logic [NUM_CHANNELS-1:0] grant,
    output logic [SEL_WIDTH-1:0]    grant_idx,
    output logic                    any_grant
);

    int c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        c         = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            c = int'(pointer) + i;
            if (c >= NUM_CHANNELS) c = c - NUM_CHANNELS;
            if (!any_grant && request[c]) begin
                any_grant = 1'b1;
                grant_idx = c[SEL_WIDTH-1:0];
            end
        end
        if (any_grant) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/mux_n_1_stream.sv
// Registered N:1 valid/ready multiplexer with direct-select and round-robin scan modes.
// Optional stall-cycle counter enabled by MUX_N_1_STREAM_STALL_COUNT_EN.
module mux_n_1_stream
    import mux_n_1_stream_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic             Clock_In,
    input  logic             Reset_n_In,
    mux_n_1_stream_if.slave  bus
);

    localparam int SEL_WIDTH = $clog2(NUM_CHANNELS);

    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data;
    state_t                  state, state_nxt;
    logic [SEL_WIDTH-1:0]    ptr, scan_idx, chosen_idx, chan_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [NUM_CHANNELS-1:0] scan_grant, rdy;
    logic                    scan_any, sel_ok, direct_ok, chosen, free, capture;
    logic                    out_valid, sel_err_q, scan_mode;

    assign ch_data   = bus.Data_In;
    assign scan_mode = (bus.Mode_In == MODE_SCAN);

    // Only non-power-of-two channel counts can see an out-of-range select.
    generate
        if ((1 << SEL_WIDTH) > NUM_CHANNELS) begin : g_sel_chk
            assign sel_ok = int'(bus.Select_In) < NUM_CHANNELS;
        end else begin : g_sel_full
            assign sel_ok = 1'b1;
        end
    endgenerate

    round_robin_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_arb (
        .request   (bus.Data_Valid_In),
        .pointer   (ptr),
        .grant     (scan_grant),
        .grant_idx (scan_idx),
        .any_grant (scan_any)
    );

    assign direct_ok  = sel_ok && bus.Data_Valid_In[bus.Select_In];
    assign chosen     = scan_mode ? scan_any : direct_ok;
    assign chosen_idx = scan_mode ? scan_idx : bus.Select_In;
    assign free       = !out_valid || bus.MUX_Result_Ready_In;
    assign capture    = Reset_n_In && bus.Enable_In && free && chosen;

    always_comb begin
        rdy = '0;
        if (capture) begin
            if (scan_mode) rdy = scan_grant;
            else           rdy[chosen_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:          if (capture) state_nxt = ACTIVE;
            ACTIVE, STALL: begin
                if (!bus.MUX_Result_Ready_In) state_nxt = STALL;
                else if (capture)             state_nxt = ACTIVE;
                else                          state_nxt = IDLE;
            end
            default:       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state != IDLE);
    end

    // Select error is reported on the edge after the offending cycle.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            data_q    <= '0;
            chan_q    <= '0;
            ptr       <= '0;
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= bus.Enable_In && free && !scan_mode && !sel_ok;
            if (capture) begin
                data_q <= ch_data[chosen_idx];
                chan_q <= chosen_idx;
                if (scan_mode)
                    ptr <= (scan_idx == SEL_WIDTH'(NUM_CHANNELS - 1)) ? '0 : scan_idx + 1'b1;
            end
        end
    end

    assign bus.Data_Ready_Out       = rdy;
    assign bus.MUX_Result_Data_Out  = data_q;
    assign bus.MUX_Result_Valid_Out = out_valid;
    assign bus.Channel_Out          = chan_q;
    assign bus.Select_Error_Out     = sel_err_q;

`ifdef MUX_N_1_STREAM_STALL_COUNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   stalled;

    assign stalled = out_valid && !bus.MUX_Result_Ready_In;

    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In)                    stall_cnt <= '0;
        else if (stalled && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.Stall_Count_Out = stall_cnt;
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Directed scoreboard bench for mux_n_1_stream: a 16-channel instance plus a 12-channel
// instance for out-of-range select.
module tb_mux_n_1_stream;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [3:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t sbq[$];
    int   wrap_seq[3] = '{3, 12, 3};

    mux_n_1_stream_if #(.NUM_CHANNELS(16), .DATA_WIDTH(8)) a ();
    mux_n_1_stream_if #(.NUM_CHANNELS(12), .DATA_WIDTH(8)) b ();

    mux_n_1_stream #(.NUM_CHANNELS(16), .DATA_WIDTH(8)) dut_a (
        .Clock_In(clk), .Reset_n_In(rst_n), .bus(a)
    );
    mux_n_1_stream #(.NUM_CHANNELS(12), .DATA_WIDTH(8)) dut_b (
        .Clock_In(clk), .Reset_n_In(rst_n), .bus(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int d);
        exp_t e;
        e.ch = ch[3:0];
        e.d  = d[7:0];
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=output expected=no-entry", tag);
        end else begin
            e = sbq.pop_front();
            check({tag, "_valid"}, 32'(a.MUX_Result_Valid_Out), 32'd1);
            check({tag, "_data"},  32'(a.MUX_Result_Data_Out),  32'(e.d));
            check({tag, "_chan"},  32'(a.Channel_Out),          32'(e.ch));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a.Enable_In = 1'b0; a.Mode_In = 1'b0; a.Select_In = '0;
        a.Data_In = '0; a.Data_Valid_In = '0; a.MUX_Result_Ready_In = 1'b1;
        b.Enable_In = 1'b0; b.Mode_In = 1'b0; b.Select_In = '0;
        b.Data_In = '0; b.Data_Valid_In = '0; b.MUX_Result_Ready_In = 1'b1;
        repeat (2) cyc();

        check("rst_valid", 32'(a.MUX_Result_Valid_Out), 32'd0);
        check("rst_data",  32'(a.MUX_Result_Data_Out),  32'd0);
        check("rst_chan",  32'(a.Channel_Out),          32'd0);
        check("rst_err",   32'(a.Select_Error_Out),     32'd0);
        check("rst_rdy",   32'(a.Data_Ready_Out),       32'd0);
`ifdef MUX_N_1_STREAM_STALL_COUNT_EN
        check("rst_stall_cnt", 32'(a.Stall_Count_Out), 32'd0);
`endif
        rst_n = 1'b1;
        cyc();

        // direct select of channel 5
        for (int i = 0; i < 16; i++) a.Data_In[i*8 +: 8] = 8'(i);
        a.Data_In[5*8 +: 8] = 8'hA5;
        a.Enable_In = 1'b1; a.Select_In = 4'd5; a.Data_Valid_In = 16'h0020;
        push(5, 'hA5);
        #1 check("direct_rdy", 32'(a.Data_Ready_Out), 32'h0020);
        cyc();
        pop_chk("direct");
        a.Data_Valid_In = 16'h0010;
        #1 check("direct_novalid_rdy", 32'(a.Data_Ready_Out), 32'd0);
        cyc();
        check("direct_novalid_out", 32'(a.MUX_Result_Valid_Out), 32'd0);

        // scan all channels, back-to-back
        a.Data_In[5*8 +: 8] = 8'd5;
        a.Mode_In = 1'b1; a.Data_Valid_In = '1;
        for (int k = 0; k < 17; k++) begin
            push(k % 16, k % 16);
            cyc();
            pop_chk("scan_all");
        end
        a.Data_Valid_In = '0;
        cyc();
        check("scan_drain", 32'(a.MUX_Result_Valid_Out), 32'd0);

        // move pointer to 13 via channel 12, then wrap between 3 and 12
        a.Data_Valid_In = 16'h1000;
        push(12, 12);
        cyc();
        pop_chk("wrap_setup");
        a.Data_Valid_In = 16'h1008;
        for (int k = 0; k < 3; k++) begin
            push(wrap_seq[k], wrap_seq[k]);
            cyc();
            pop_chk("wrap");
        end
        a.Data_Valid_In = '0;
        cyc();
        check("wrap_drain", 32'(a.MUX_Result_Valid_Out), 32'd0);

        // stall for 4 cycles with a new word waiting
        a.Mode_In = 1'b0; a.Select_In = 4'd7;
        a.Data_In[7*8 +: 8] = 8'h77; a.Data_Valid_In = 16'h0080;
        push(7, 'h77);
        cyc();
        pop_chk("stall_first");
        a.MUX_Result_Ready_In = 1'b0;
        a.Data_In[7*8 +: 8] = 8'h78;
        for (int k = 0; k < 4; k++) begin
            #1 check("stall_rdy", 32'(a.Data_Ready_Out), 32'd0);
            cyc();
            check("stall_valid", 32'(a.MUX_Result_Valid_Out), 32'd1);
            check("stall_data",  32'(a.MUX_Result_Data_Out),  32'h77);
            check("stall_chan",  32'(a.Channel_Out),          32'd7);
        end
`ifdef MUX_N_1_STREAM_STALL_COUNT_EN
        check("stall_cnt4", 32'(a.Stall_Count_Out), 32'd4);
`endif
        a.MUX_Result_Ready_In = 1'b1;
        #1 check("release_rdy", 32'(a.Data_Ready_Out), 32'h0080);
        push(7, 'h78);
        cyc();
        pop_chk("release_replace");

        // enable low: pending word drains, nothing new captured
        a.Enable_In = 1'b0; a.MUX_Result_Ready_In = 1'b0;
        cyc();
        check("en_hold_valid", 32'(a.MUX_Result_Valid_Out), 32'd1);
        check("en_hold_data",  32'(a.MUX_Result_Data_Out),  32'h78);
        a.MUX_Result_Ready_In = 1'b1;
        #1 check("en_low_rdy", 32'(a.Data_Ready_Out), 32'd0);
        cyc();
        check("en_drained", 32'(a.MUX_Result_Valid_Out), 32'd0);
        cyc();
        check("en_no_capture", 32'(a.MUX_Result_Valid_Out), 32'd0);

        // reset while stalled
        a.Enable_In = 1'b1;
        push(7, 'h78);
        cyc();
        pop_chk("pre_reset");
        a.MUX_Result_Ready_In = 1'b0;
        cyc();
        check("pre_reset_stall", 32'(a.MUX_Result_Valid_Out), 32'd1);
        rst_n = 1'b0;
        cyc();
        check("mid_rst_valid", 32'(a.MUX_Result_Valid_Out), 32'd0);
        check("mid_rst_data",  32'(a.MUX_Result_Data_Out),  32'd0);
        check("mid_rst_chan",  32'(a.Channel_Out),          32'd0);
`ifdef MUX_N_1_STREAM_STALL_COUNT_EN
        check("mid_rst_stall_cnt", 32'(a.Stall_Count_Out), 32'd0);
`endif
        rst_n = 1'b1;
        a.Data_Valid_In = '0; a.MUX_Result_Ready_In = 1'b1;
        cyc();

        // 12-channel build: out-of-range select
        b.Data_In[3*8 +: 8] = 8'h33;
        b.Data_Valid_In = '1; b.Enable_In = 1'b1; b.Mode_In = 1'b0; b.Select_In = 4'd14;
        #1 check("badsel_rdy", 32'(b.Data_Ready_Out), 32'd0);
        cyc();
        check("badsel_err",   32'(b.Select_Error_Out),     32'd1);
        check("badsel_valid", 32'(b.MUX_Result_Valid_Out), 32'd0);
        b.Select_In = 4'd3;
        #1 check("goodsel_rdy", 32'(b.Data_Ready_Out), 32'h008);
        cyc();
        check("goodsel_err",   32'(b.Select_Error_Out),     32'd0);
        check("goodsel_valid", 32'(b.MUX_Result_Valid_Out), 32'd1);
        check("goodsel_data",  32'(b.MUX_Result_Data_Out),  32'h33);
        check("goodsel_chan",  32'(b.Channel_Out),          32'd3);
        b.Enable_In = 1'b0;
        cyc();
        check("goodsel_drain", 32'(b.MUX_Result_Valid_Out), 32'd0);

        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_n_1_stream.md
Name: mux_n_1_stream

Overview:
- Parametrised, registered N:1 streaming multiplexer; successor to the fixed 16:1 single-bit combinational MUX.
- Selects one of NUM_CHANNELS valid/ready input channels of DATA_WIDTH bits.
- Two modes: direct select and round-robin auto-scan.
- Output is a single registered valid/ready stream feeding downstream serialisers/converters in the Data_Selectors_and_Converters group.

Parameters:
- NUM_CHANNELS, 16, number of input channels (2..64, need not be a power of two)
- DATA_WIDTH, 8, bits per channel
- SEL_WIDTH, $clog2(NUM_CHANNELS), derived localparam, select/channel index width

Ports:
- Clock_In  in  1  single clock; all logic on rising edge
- Reset_n_In  in  1  synchronous, active-low reset
- Enable_In  in  1  1 = new captures allowed
- Mode_In  in  1  0 = direct select, 1 = round-robin scan
- Select_In  in  SEL_WIDTH  channel index used in direct mode
- Data_In  in  NUM_CHANNELS*DATA_WIDTH  packed channels; channel i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- Data_Valid_In  in  NUM_CHANNELS  per-channel valid
- Data_Ready_Out  out  NUM_CHANNELS  per-channel ready; combinational, at most one bit high
- MUX_Result_Data_Out  out  DATA_WIDTH  registered selected data
- MUX_Result_Valid_Out  out  1  output valid
- MUX_Result_Ready_In  in  1  downstream ready
- Channel_Out  out  SEL_WIDTH  index of the channel held in the output register
- Select_Error_Out  out  1  one-cycle pulse when Select_In >= NUM_CHANNELS in direct mode while capture is possible

Behaviour:
- Reset (Reset_n_In=0 at a clock edge):
  - All outputs = 0.
  - Round-robin pointer = 0; FSM = IDLE.
  - Reset mid-transfer discards held data without a handshake.
- Slot free condition: free = !MUX_Result_Valid_Out || MUX_Result_Ready_In.
- Capture condition: Enable_In && free && a channel is chosen.
- Channel choice:
  - Direct mode: chosen channel = Select_In, only if Data_Valid_In[Select_In] = 1 and Select_In < NUM_CHANNELS.
  - Scan mode: first valid channel searched from pointer upward, wrapping N-1 -> 0.
- On capture:
  - Data_Ready_Out[chosen] = 1 in the same cycle (combinational).
  - Next edge: data -> MUX_Result_Data_Out, index -> Channel_Out, MUX_Result_Valid_Out = 1.
  - Latency is 1 cycle. Throughput is 1 word/cycle while MUX_Result_Ready_In = 1.
- Scan pointer: after a scan-mode grant of channel g, pointer = (g+1) mod NUM_CHANNELS. Pointer is unchanged in direct mode and on cycles with no grant.
- No capture, while output accepted: MUX_Result_Valid_Out -> 0 at the next edge.
- Stall (valid && !ready): MUX_Result_Data_Out and Channel_Out are held stable; all Data_Ready_Out = 0.
- FSM states:
  - IDLE: output empty. -> ACTIVE on capture.
  - ACTIVE: output valid and being accepted. ACTIVE -> STALL when !MUX_Result_Ready_In. ACTIVE -> IDLE when accepted with no new capture.
  - STALL: output valid, not accepted. STALL -> ACTIVE when ready and a capture occurs. STALL -> IDLE when ready and no capture occurs.
- Enable_In = 0: no new captures. A pending output still drains normally.
- Mode_In change: takes effect for the next capture only; the held word is unaffected.
- Invalid select: Select_In >= NUM_CHANNELS in direct mode gives no capture and Select_Error_Out = 1 for each such cycle with Enable_In && free.
- Simultaneous downstream accept and new capture in the same cycle: output is replaced with no bubble.

Optional Feature:
- MUX_N_1_STREAM_STALL_COUNT_EN defined:
  - Adds output port Stall_Count_Out [15:0].
  - Counts cycles with MUX_Result_Valid_Out && !MUX_Result_Ready_In; saturates at 16'hFFFF.
  - Cleared by reset.
- Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Package mux_n_1_stream_pkg:
  - State enum typedef (IDLE, ACTIVE, STALL).
  - Mode constants MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1.
  - Stall counter width constant (16).
- Sub-module round_robin_arbiter: inputs request vector and pointer; outputs one-hot grant, grant index and any_grant. Parametrised by NUM_CHANNELS.

Test Plan (NUM_CHANNELS=16, DATA_WIDTH=8):
- Direct mode, Select_In=5, channel 5 = 8'hA5 valid, ready=1 -> Data_Ready_Out=16'h0020 that cycle; next edge MUX_Result_Data_Out=8'hA5, Channel_Out=5, valid=1.
- Scan mode, all 16 channels valid, channel i = i, ready held 1 -> output sequence 0,1,...,15,0 on consecutive cycles, no bubbles.
- Scan mode, only channels 3 and 12 valid, pointer at 13 -> grants 3 then 12 then 3 (wrap-around).
- Output valid with ready=0 for 4 cycles -> data and Channel_Out stable, Data_Ready_Out=0; with STALL_COUNT_EN, Stall_Count_Out=4. On ready=1, next capture happens in the same cycle.
- Direct mode, NUM_CHANNELS=12 build, Select_In=14 -> Select_Error_Out=1, no capture, valid stays 0.
- Reset_n_In=0 during STALL and Enable_In=0 with a pending output -> reset clears all outputs next edge; enable-low case drains the pending word with no further captures.
